// File: rtl/osc_reset_sequencer.sv
// osc_reset_sequencer: waits for oscillator settle and filtered PLL lock, releases reset stages in order, then reports ready
module osc_reset_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int STARTUP_CYCLES = 1024,
    parameter int LOCK_FILT      = 64,
    parameter int STAGE_GAP      = 16,
    parameter int HB_DIV         = 80000000
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  pll_lock_i,
    input  logic                  restart_i,
    output logic [NUM_STAGES-1:0] stage_rst_n_o,
    output logic                  ready_o,
    output logic                  fault_o,
    output logic                  heartbeat_o,
    output logic [2:0]            state_o
);
    // One counter serves settle, lock filter and stage gap; it is sized for the largest of the three.
    localparam int CMAX = (STARTUP_CYCLES > LOCK_FILT)
                        ? ((STARTUP_CYCLES > STAGE_GAP) ? STARTUP_CYCLES : STAGE_GAP)
                        : ((LOCK_FILT > STAGE_GAP) ? LOCK_FILT : STAGE_GAP);
    localparam int CW = $clog2(CMAX + 1);
    localparam int HW = $clog2(HB_DIV + 1);
    localparam logic [CW-1:0] OSC_LAST  = CW'(STARTUP_CYCLES - 1);
    localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [HW-1:0] HB_LAST   = HW'(HB_DIV - 1);

    typedef enum logic [2:0] {
        WAIT_OSC  = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        FAULTED   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  ready_q, ready_d;
    logic                  fault_q, fault_d;
    logic [HW-1:0]         hb_cnt_q;
    logic                  hb_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= WAIT_OSC;
            cnt_q    <= '0;
            stage_q  <= '0;
            ready_q  <= 1'b0;
            fault_q  <= 1'b0;
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            ready_q  <= ready_d;
            fault_q  <= fault_d;
            hb_cnt_q <= (hb_cnt_q == HB_LAST) ? '0 : hb_cnt_q + 1'b1;
            hb_q     <= (hb_cnt_q == HB_LAST) ? ~hb_q : hb_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        ready_d = ready_q;
        fault_d = fault_q;
        case (state_q)
            WAIT_OSC: begin
                cnt_d   = (cnt_q == OSC_LAST) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == OSC_LAST) ? WAIT_LOCK : WAIT_OSC;
            end
            WAIT_LOCK: begin
                if (!pll_lock_i) begin
                    cnt_d = '0;
                end else if (cnt_q == FILT_LAST) begin
                    cnt_d   = '0;
                    stage_d = NUM_STAGES'(1);
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!pll_lock_i) begin
                    cnt_d   = '0;
                    stage_d = '0;
                    state_d = WAIT_LOCK;
                end else if (cnt_q == GAP_LAST) begin
                    // Stages form a thermometer code, so the top bit marks the final release.
                    cnt_d   = '0;
                    stage_d = stage_q[NUM_STAGES-1] ? stage_q : NUM_STAGES'({stage_q, 1'b1});
                    ready_d = stage_q[NUM_STAGES-1];
                    state_d = stage_q[NUM_STAGES-1] ? RUN : RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!pll_lock_i) begin
                    stage_d = '0;
                    ready_d = 1'b0;
                    fault_d = 1'b1;
                    state_d = FAULTED;
                end
            end
            FAULTED: begin
                if (restart_i) begin
                    cnt_d   = '0;
                    fault_d = 1'b0;
                    state_d = WAIT_LOCK;
                end
            end
            default: state_d = WAIT_OSC;
        endcase
    end

    assign stage_rst_n_o = stage_q;
    assign ready_o       = ready_q;
    assign fault_o       = fault_q;
    assign heartbeat_o   = hb_q;
    assign state_o       = state_q;
endmodule
